// File: rtl/regf_write_arbiter.sv
// Register-file writeback arbiter: three one-entry source slots (alu, ld, lnk),
// WAW blocking on outstanding indices, round-robin or fixed-priority drain, read-operand stall.
module regf_write_arbiter #(
    parameter int LINK_INDEX = 31,
    parameter bit RR_ENABLE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_req,
    input  logic [4:0]  alu_index,
    input  logic [31:0] alu_data,
    output logic        alu_ack,
    input  logic        ld_req,
    input  logic [4:0]  ld_index,
    input  logic [31:0] ld_data,
    output logic        ld_ack,
    input  logic        lnk_req,
    input  logic [31:0] lnk_data,
    output logic        lnk_ack,
    input  logic [4:0]  rd1_index,
    input  logic [4:0]  rd2_index,
    output logic        stall,
    output logic        wr_en,
    output logic [4:0]  wr_index,
    output logic [31:0] wr_data
);

    // Handshake: a source holds req with index/data stable until ack; the transfer
    // happens on the rising edge where req && ack. ack depends combinationally on req/index.

    localparam logic [4:0] LINK_IDX = LINK_INDEX[4:0];

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_LNK = 2'd2
    } src_t;

    logic        alu_v, ld_v, lnk_v;
    logic [4:0]  alu_idx, ld_idx;
    logic [31:0] alu_d, ld_d, lnk_d;
    src_t        last_grant;

    logic        g_alu, g_ld, g_lnk;
    logic        grant_any;
    logic [4:0]  sel_idx;
    logic [31:0] sel_data;
    src_t        sel_src;
    logic [31:0] pending;

    // Every index that still has a write on its way to the register file.
    always_comb begin
        pending = '0;
        if (alu_v) pending[alu_idx] = 1'b1;
        if (ld_v)  pending[ld_idx]  = 1'b1;
        if (lnk_v) pending[LINK_IDX] = 1'b1;
        if (wr_en) pending[wr_index] = 1'b1;
        pending[0] = 1'b0;
    end

    assign stall = ((rd1_index != 5'd0) && pending[rd1_index]) ||
                   ((rd2_index != 5'd0) && pending[rd2_index]);

    // Same-index collisions in one cycle go to the higher-priority requester.
    always_comb begin
        lnk_ack = !rst && lnk_req && !lnk_v && !pending[LINK_IDX];
        ld_ack  = !rst && ld_req && !ld_v && !pending[ld_index] &&
                  !(lnk_req && (ld_index == LINK_IDX));
        alu_ack = !rst && alu_req && !alu_v && !pending[alu_index] &&
                  !(lnk_req && (alu_index == LINK_IDX)) &&
                  !(ld_req && (ld_index == alu_index));
    end

    // Pick one valid slot; round-robin starts after the last granted source.
    always_comb begin
        g_alu = 1'b0;
        g_ld  = 1'b0;
        g_lnk = 1'b0;
        if (RR_ENABLE) begin
            case (last_grant)
                SRC_ALU: begin
                    if (ld_v)       g_ld  = 1'b1;
                    else if (lnk_v) g_lnk = 1'b1;
                    else if (alu_v) g_alu = 1'b1;
                end
                SRC_LD: begin
                    if (lnk_v)      g_lnk = 1'b1;
                    else if (alu_v) g_alu = 1'b1;
                    else if (ld_v)  g_ld  = 1'b1;
                end
                default: begin
                    if (alu_v)      g_alu = 1'b1;
                    else if (ld_v)  g_ld  = 1'b1;
                    else if (lnk_v) g_lnk = 1'b1;
                end
            endcase
        end else begin
            if (lnk_v)      g_lnk = 1'b1;
            else if (ld_v)  g_ld  = 1'b1;
            else if (alu_v) g_alu = 1'b1;
        end
    end

    always_comb begin
        grant_any = g_alu || g_ld || g_lnk;
        sel_idx   = alu_idx;
        sel_data  = alu_d;
        sel_src   = SRC_ALU;
        if (g_ld) begin
            sel_idx  = ld_idx;
            sel_data = ld_d;
            sel_src  = SRC_LD;
        end else if (g_lnk) begin
            sel_idx  = LINK_IDX;
            sel_data = lnk_d;
            sel_src  = SRC_LNK;
        end
    end

    // A granted slot is still valid this cycle, so its ack is low: no same-cycle refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_v      <= 1'b0;
            ld_v       <= 1'b0;
            lnk_v      <= 1'b0;
            alu_idx    <= '0;
            ld_idx     <= '0;
            alu_d      <= '0;
            ld_d       <= '0;
            lnk_d      <= '0;
            last_grant <= SRC_LNK;
            wr_en      <= 1'b0;
            wr_index   <= '0;
            wr_data    <= '0;
        end else begin
            if (g_alu) begin
                alu_v <= 1'b0;
            end else if (alu_ack && (alu_index != 5'd0)) begin
                alu_v   <= 1'b1;
                alu_idx <= alu_index;
                alu_d   <= alu_data;
            end

            if (g_ld) begin
                ld_v <= 1'b0;
            end else if (ld_ack && (ld_index != 5'd0)) begin
                ld_v   <= 1'b1;
                ld_idx <= ld_index;
                ld_d   <= ld_data;
            end

            if (g_lnk) begin
                lnk_v <= 1'b0;
            end else if (lnk_ack && (LINK_IDX != 5'd0)) begin
                lnk_v <= 1'b1;
                lnk_d <= lnk_data;
            end

            if (grant_any) begin
                wr_en      <= 1'b1;
                wr_index   <= sel_idx;
                wr_data    <= sel_data;
                last_grant <= sel_src;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regf_write_arbiter.sv
// Directed bench for regf_write_arbiter: round-robin instance checked in detail,
// fixed-priority instance checked for lnk-first ordering.
module tb_regf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_req, ld_req, lnk_req;
    logic [4:0]  alu_index, ld_index;
    logic [31:0] alu_data, ld_data, lnk_data;
    logic [4:0]  rd1_index, rd2_index;

    logic        rr_alu_ack, rr_ld_ack, rr_lnk_ack, rr_stall, rr_wr_en;
    logic [4:0]  rr_wr_index;
    logic [31:0] rr_wr_data;
    logic        fp_alu_ack, fp_ld_ack, fp_lnk_ack, fp_stall, fp_wr_en;
    logic [4:0]  fp_wr_index;
    logic [31:0] fp_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    regf_write_arbiter #(.LINK_INDEX(31), .RR_ENABLE(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .alu_req(alu_req), .alu_index(alu_index), .alu_data(alu_data), .alu_ack(rr_alu_ack),
        .ld_req(ld_req), .ld_index(ld_index), .ld_data(ld_data), .ld_ack(rr_ld_ack),
        .lnk_req(lnk_req), .lnk_data(lnk_data), .lnk_ack(rr_lnk_ack),
        .rd1_index(rd1_index), .rd2_index(rd2_index), .stall(rr_stall),
        .wr_en(rr_wr_en), .wr_index(rr_wr_index), .wr_data(rr_wr_data)
    );

    regf_write_arbiter #(.LINK_INDEX(31), .RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .alu_req(alu_req), .alu_index(alu_index), .alu_data(alu_data), .alu_ack(fp_alu_ack),
        .ld_req(ld_req), .ld_index(ld_index), .ld_data(ld_data), .ld_ack(fp_ld_ack),
        .lnk_req(lnk_req), .lnk_data(lnk_data), .lnk_ack(fp_lnk_ack),
        .rd1_index(rd1_index), .rd2_index(rd2_index), .stall(fp_stall),
        .wr_en(fp_wr_en), .wr_index(fp_wr_index), .wr_data(fp_wr_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_req = 1'b0; ld_req = 1'b0; lnk_req = 1'b0;
        alu_index = '0; ld_index = '0;
        alu_data = '0; ld_data = '0; lnk_data = '0;
        rd1_index = '0; rd2_index = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] idx, input logic [31:0] data);
        chk({tag, "_en"}, 32'(rr_wr_en), 32'(en));
        if (en) begin
            chk({tag, "_idx"}, 32'(rr_wr_index), 32'(idx));
            chk({tag, "_data"}, rr_wr_data, data);
        end
    endtask

    task automatic chk_fp(input string tag, input logic en, input logic [4:0] idx);
        chk({tag, "_en"}, 32'(fp_wr_en), 32'(en));
        if (en) chk({tag, "_idx"}, 32'(fp_wr_index), 32'(idx));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(rr_wr_en), 32'd0);
        chk("rst_wr_index", 32'(rr_wr_index), 32'd0);
        chk("rst_wr_data", rr_wr_data, 32'd0);
        chk("rst_stall", 32'(rr_stall), 32'd0);
        rst = 1'b0;

        // single alu write, latency and stall window
        alu_req = 1'b1; alu_index = 5'd5; alu_data = 32'd16; rd1_index = 5'd5;
        #1;
        chk("t1_ack", 32'(rr_alu_ack), 32'd1);
        chk("t1_stall_pre", 32'(rr_stall), 32'd0);
        tick();
        alu_req = 1'b0;
        chk("t1_stall_e0", 32'(rr_stall), 32'd1);
        chk_wr("t1_e0", 1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("t1_e1", 1'b1, 5'd5, 32'd16);
        chk("t1_stall_e1", 32'(rr_stall), 32'd1);
        tick();
        chk_wr("t1_e2", 1'b0, 5'd0, 32'd0);
        chk("t1_hold_idx", 32'(rr_wr_index), 32'd5);
        chk("t1_hold_data", rr_wr_data, 32'd16);
        chk("t1_stall_e2", 32'(rr_stall), 32'd0);

        // three sources at once, round-robin order alu, ld, lnk
        do_reset();
        alu_req = 1'b1; alu_index = 5'd1; alu_data = 32'd22;
        ld_req = 1'b1; ld_index = 5'd2; ld_data = 32'd9;
        lnk_req = 1'b1; lnk_data = 32'd100;
        #1;
        chk("t2_alu_ack", 32'(rr_alu_ack), 32'd1);
        chk("t2_ld_ack", 32'(rr_ld_ack), 32'd1);
        chk("t2_lnk_ack", 32'(rr_lnk_ack), 32'd1);
        tick();
        idle_inputs();
        rd2_index = 5'd31;
        #1;
        chk("t2_stall_rd2", 32'(rr_stall), 32'd1);
        tick();
        chk_wr("t2_w1", 1'b1, 5'd1, 32'd22);
        tick();
        chk_wr("t2_w2", 1'b1, 5'd2, 32'd9);
        tick();
        chk_wr("t2_w3", 1'b1, 5'd31, 32'd100);
        tick();
        chk_wr("t2_w4", 1'b0, 5'd0, 32'd0);

        // WAW block: alu waits for the ld write to 7 to leave wr_en
        do_reset();
        ld_req = 1'b1; ld_index = 5'd7; ld_data = 32'd70;
        #1;
        chk("t3_ld_ack", 32'(rr_ld_ack), 32'd1);
        tick();
        ld_req = 1'b0;
        alu_req = 1'b1; alu_index = 5'd7; alu_data = 32'd77;
        #1;
        chk("t3_alu_ack_c1", 32'(rr_alu_ack), 32'd0);
        tick();
        chk_wr("t3_e1", 1'b1, 5'd7, 32'd70);
        chk("t3_alu_ack_c2", 32'(rr_alu_ack), 32'd0);
        tick();
        chk_wr("t3_e2", 1'b0, 5'd0, 32'd0);
        chk("t3_alu_ack_c3", 32'(rr_alu_ack), 32'd1);
        tick();
        alu_req = 1'b0;
        chk_wr("t3_e3", 1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("t3_e4", 1'b1, 5'd7, 32'd77);

        // same-index collisions, then index 0 writes are dropped
        do_reset();
        alu_req = 1'b1; alu_index = 5'd31;
        ld_req = 1'b1; ld_index = 5'd31;
        lnk_req = 1'b1;
        #1;
        chk("t4_lnk_win", 32'(rr_lnk_ack), 32'd1);
        chk("t4_ld_lose", 32'(rr_ld_ack), 32'd0);
        chk("t4_alu_lose", 32'(rr_alu_ack), 32'd0);
        lnk_req = 1'b0; alu_index = 5'd8; ld_index = 5'd8;
        #1;
        chk("t4_ld_win", 32'(rr_ld_ack), 32'd1);
        chk("t4_alu_lose8", 32'(rr_alu_ack), 32'd0);
        ld_req = 1'b0; alu_index = 5'd0; alu_data = 32'd20; rd1_index = 5'd0;
        #1;
        chk("t4_zero_ack", 32'(rr_alu_ack), 32'd1);
        chk("t4_zero_stall", 32'(rr_stall), 32'd0);
        tick();
        alu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_zero_noen", 32'(rr_wr_en), 32'd0);
            chk("t4_zero_stall_post", 32'(rr_stall), 32'd0);
            tick();
        end

        // reset mid-cycle with two slots valid and a write on wr_en
        do_reset();
        alu_req = 1'b1; alu_index = 5'd4; alu_data = 32'd44;
        ld_req = 1'b1; ld_index = 5'd6; ld_data = 32'd66;
        lnk_req = 1'b1; lnk_data = 32'd100;
        tick();
        idle_inputs();
        rd1_index = 5'd6;
        tick();
        chk_wr("t5_e1", 1'b1, 5'd4, 32'd44);
        #2;
        rst = 1'b1;
        alu_req = 1'b1; alu_index = 5'd9; alu_data = 32'd99;
        #1;
        chk("t5_rst_en", 32'(rr_wr_en), 32'd0);
        chk("t5_rst_idx", 32'(rr_wr_index), 32'd0);
        chk("t5_rst_data", rr_wr_data, 32'd0);
        chk("t5_rst_stall", 32'(rr_stall), 32'd0);
        chk("t5_rst_ack", 32'(rr_alu_ack), 32'd0);
        #1;
        rst = 1'b0;
        alu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_post_noen", 32'(rr_wr_en), 32'd0);
        end

        // fixed priority vs round-robin under continuous alu + lnk requests
        do_reset();
        alu_req = 1'b1; alu_index = 5'd3; alu_data = 32'd33;
        lnk_req = 1'b1; lnk_data = 32'd55;
        tick();
        tick();
        chk_fp("t6_e1", 1'b1, 5'd31);
        chk("t6_e1_data", fp_wr_data, 32'd55);
        chk("t6_rr_e1_idx", 32'(rr_wr_index), 32'd3);
        tick();
        chk_fp("t6_e2", 1'b1, 5'd3);
        tick();
        chk_fp("t6_e3", 1'b0, 5'd0);
        tick();
        chk_fp("t6_e4", 1'b1, 5'd31);
        tick();
        chk_fp("t6_e5", 1'b1, 5'd3);
        tick();
        chk_fp("t6_e6", 1'b0, 5'd0);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
